prog_loader: RTL
================

Name: prog_loader

Overview:
- UART program loader: receiving end of the core's serial link, counterpart to the single-byte UART transmitter on the same line.
- Receives an 8N1 byte stream on rxd and assembles a length-prefixed program image.
- Drives the top-level prog_loadaddr / prog_loaddata / prog_dmem_we / prog_imem_we / loaded nets, which fill dmem (32-bit) and imem (128-bit) while prog_loading holds the pipeline in reset.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 4.
- ADDR_W, `ADDR_LEN, width of addr output.

Ports:
- clk  input  1  core clock
- reset_x  input  1  asynchronous active-low reset
- rxd  input  1  UART serial input, idle high, asynchronous to clk
- addr  output  ADDR_W  byte address of the word being written
- data  output  128  load data; newest 32-bit word in [127:96]; completed 16-byte block with byte0 in [7:0]
- we_32  output  1  dmem write strobe, one cycle per completed word
- we_128  output  1  imem write strobe, one cycle per completed 16-byte block
- done  output  1  image fully loaded; sticky until reset
- err  output  1  sticky framing-error flag

Behaviour:
- Reset:
  - Asynchronous, active-low: all flops clear immediately on reset_x low.
  - On reset: addr=0, data=0, we_32=0, we_128=0, done=0, err=0, both FSMs idle, synchronizer flops set to 1.
- Receiver (uart_rx_byte):
  - rxd passes through a 2-flop synchronizer.
  - FSM states: IDLE -> START -> BITS -> STOP -> IDLE.
  - IDLE: a 0 on the synchronized line starts a counter; the line is resampled at CLKS_PER_BIT/2. If it is high there, treat as a glitch and return to IDLE with no byte.
  - BITS: 8 data bits, LSB first, each sampled every CLKS_PER_BIT.
  - STOP: stop bit sampled at its midpoint.
    - Stop bit = 1: byte_valid pulses for 1 cycle with byte.
    - Stop bit = 0: byte dropped, err set, return to IDLE only after the line reads 1 (no re-trigger on a held break).
- Loader FSM states:
  - HDR:
    - First 4 accepted bytes form the 32-bit little-endian length N.
    - N[3:0] is ignored; effective length L = N & ~15.
    - If L=0 after the 4th byte, go to FIN.
  - LOAD:
    - Each byte_valid: data <= {byte, data[127:8]}; byte counter increments.
    - On the 4th byte of a word: we_32=1 in the following cycle; data already contains the byte; addr = word start byte offset (0, 4, 8, ...).
    - On every 16th byte: we_128=1 in the same cycle as that word's we_32, with the same addr (offset of the last word; imem uses addr[12:4]).
    - After byte L: go to FIN.
  - FIN: done=1 held. All further bytes are ignored; no more strobes.
- Strobes are single-cycle. At most one byte arrives per 10*CLKS_PER_BIT cycles, so strobes never overlap consecutive words.
- addr and data stay stable until the next accepted byte.
- A framing error does not advance the byte counter (the byte is lost); loading continues.
- Reset mid-load: everything restarts at HDR. Partial writes already issued are not undone.

Decomposition:
- Shared constants file (alongside define.v): UART frame constants (DATA_BITS=8), loader state encodings, rx state encodings.
- One sub-module, uart_rx_byte (synchronizer, bit timer, rx FSM; outputs byte, byte_valid, frame_err).
- prog_loader holds the header/counter/shift logic.

Test Plan:
- CLKS_PER_BIT=4. Send header 20 00 00 00, then bytes 00..1F:
  - 8 we_32 pulses at addr 0, 4, ..., 28; on the first, data[127:96]=0x03020100.
  - we_128 at addr 12 with data=0x0F0E..0100, and at addr 28 with data=0x1F1E..1110.
  - done=1 after the last strobe.
- Header 00 00 00 00 -> done=1 after the 4th byte, no strobes; then send 5 more bytes -> no strobes, done stays 1.
- Header 13 00 00 00 (N=19) -> L=16: exactly 4 we_32 and 1 we_128, then done.
- Byte with stop bit forced 0 mid-payload -> err=1, byte not counted; the next good byte completes the word normally.
- Low glitch on rxd of 1 cycle (shorter than half a bit) in IDLE -> no byte_valid, no state change.
- Assert reset_x low after 9 payload bytes -> outputs return to reset values asynchronously; a fresh header+16-byte stream then loads with addr starting at 0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared constants for the UART program loader.
//   - UART frame constants (data bits per frame)
//   - receiver and loader state encodings
//   - effective_len(): rounds a raw header length down to whole 16-byte blocks
package prog_loader_pkg;

  localparam int DATA_BITS   = 8;
  localparam int ADDR_LEN    = 32;
  localparam int LEN_W       = 32;
  localparam int BLOCK_BYTES = 16;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_BITS  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    LD_HDR  = 2'd0,
    LD_LOAD = 2'd1,
    LD_FIN  = 2'd2
  } ld_state_t;

  // The low nibble of the header length is ignored: only whole blocks load.
  function automatic logic [LEN_W-1:0] effective_len(input logic [LEN_W-1:0] n);
    return n & {{(LEN_W-4){1'b1}}, 4'b0000};
  endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// uart_rx_byte: 8N1 UART receiver.
//   clk, reset_x  : core clock, asynchronous active-low reset
//   rxd           : serial input, idle high, asynchronous to clk
//   rx_byte       : last received byte (valid while byte_valid is high)
//   byte_valid    : one-cycle pulse per correctly framed byte
//   frame_err     : one-cycle pulse when a stop bit is sampled low
module uart_rx_byte
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 reset_x,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 byte_valid,
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic [1:0]           sync_r;
  logic                 rx_s;
  rx_state_t            state_r, state_next;
  logic [CNT_W-1:0]     cnt_r, cnt_next;
  logic [BIT_W-1:0]     bit_r, bit_next;
  logic [DATA_BITS-1:0] shift_r, shift_next;
  logic [DATA_BITS-1:0] byte_r, byte_next;
  logic                 valid_r, valid_next;
  logic                 ferr_r, ferr_next;
  logic                 tick_s;

  assign rx_s       = sync_r[1];
  assign tick_s     = (cnt_r == LAST_CNT);
  assign rx_byte    = byte_r;
  assign byte_valid = valid_r;
  assign frame_err  = ferr_r;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rxd};
    end
  end

  // Receiver next-state, bit timer and shift logic.
  always_comb begin
    state_next = state_r;
    cnt_next   = cnt_r;
    bit_next   = bit_r;
    shift_next = shift_r;
    byte_next  = byte_r;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (state_r)
      RX_IDLE: begin
        cnt_next = '0;
        if (!rx_s) begin
          state_next = RX_START;
        end else begin
          state_next = RX_IDLE;
        end
      end
      RX_START: begin
        // Re-check the line half a bit in; a high level means a glitch.
        if (cnt_r == HALF_CNT) begin
          cnt_next = '0;
          bit_next = '0;
          if (!rx_s) begin
            state_next = RX_BITS;
          end else begin
            state_next = RX_IDLE;
          end
        end else begin
          cnt_next = cnt_r + CNT_W'(1);
        end
      end
      RX_BITS: begin
        if (tick_s) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_r[DATA_BITS-1:1]};
          if (bit_r == LAST_BIT) begin
            state_next = RX_STOP;
          end else begin
            bit_next = bit_r + BIT_W'(1);
          end
        end else begin
          cnt_next = cnt_r + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (tick_s) begin
          cnt_next = '0;
          if (rx_s) begin
            valid_next = 1'b1;
            byte_next  = shift_r;
            state_next = RX_IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = RX_BREAK;
          end
        end else begin
          cnt_next = cnt_r + CNT_W'(1);
        end
      end
      RX_BREAK: begin
        // Hold here until the line recovers so a long break is not re-read.
        if (rx_s) begin
          state_next = RX_IDLE;
        end else begin
          state_next = RX_BREAK;
        end
      end
      default: begin
        state_next = RX_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_r <= RX_IDLE;
      cnt_r   <= '0;
      bit_r   <= '0;
      shift_r <= '0;
      byte_r  <= '0;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      state_r <= state_next;
      cnt_r   <= cnt_next;
      bit_r   <= bit_next;
      shift_r <= shift_next;
      byte_r  <= byte_next;
      valid_r <= valid_next;
      ferr_r  <= ferr_next;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: UART program loader.
//   Receives a 4-byte little-endian length header followed by the image and
//   emits dmem (32-bit) and imem (128-bit) write strobes.
//   clk, reset_x : core clock, asynchronous active-low reset
//   rxd          : UART serial input
//   addr         : byte offset of the word being written
//   data         : newest word in [127:96]; full block with byte0 in [7:0]
//   we_32        : one pulse per completed 32-bit word
//   we_128       : one pulse per completed 16-byte block (with that word's we_32)
//   done         : image fully loaded, sticky
//   err          : sticky framing-error flag
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = ADDR_LEN
) (
  input  logic              clk,
  input  logic              reset_x,
  input  logic              rxd,
  output logic [ADDR_W-1:0] addr,
  output logic [127:0]      data,
  output logic              we_32,
  output logic              we_128,
  output logic              done,
  output logic              err
);

  logic [DATA_BITS-1:0] rx_byte;
  logic                 byte_valid;
  logic                 frame_err;

  ld_state_t            ld_r, ld_next;
  logic                 hdr_take_s;
  logic                 data_take_s;
  logic [1:0]           hdr_cnt_r;
  logic [LEN_W-1:0]     len_r;
  logic [LEN_W-1:0]     hdr_word_s;
  logic [LEN_W-1:0]     byte_cnt_r;
  logic [LEN_W-1:0]     cnt_inc_s;
  logic [LEN_W-1:0]     word_start_s;
  logic [ADDR_W-1:0]    addr_r;
  logic [127:0]         data_r;
  logic                 we_32_r;
  logic                 we_128_r;
  logic                 done_r;
  logic                 err_r;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset_x   (reset_x),
    .rxd       (rxd),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  // Header bytes arrive LSB first, so each new byte enters at the top.
  assign hdr_word_s   = {rx_byte, len_r[LEN_W-1:DATA_BITS]};
  assign cnt_inc_s    = byte_cnt_r + 32'd1;
  assign word_start_s = cnt_inc_s - 32'd4;

  assign addr   = addr_r;
  assign data   = data_r;
  assign we_32  = we_32_r;
  assign we_128 = we_128_r;
  assign done   = done_r;
  assign err    = err_r;

  // Loader state register.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      ld_r <= LD_HDR;
    end else begin
      ld_r <= ld_next;
    end
  end

  // Loader next-state and byte routing.
  always_comb begin
    ld_next     = ld_r;
    hdr_take_s  = 1'b0;
    data_take_s = 1'b0;
    case (ld_r)
      LD_HDR: begin
        if (byte_valid) begin
          hdr_take_s = 1'b1;
          if (hdr_cnt_r == 2'd3) begin
            if (effective_len(hdr_word_s) == 32'd0) begin
              ld_next = LD_FIN;
            end else begin
              ld_next = LD_LOAD;
            end
          end else begin
            ld_next = LD_HDR;
          end
        end else begin
          ld_next = LD_HDR;
        end
      end
      LD_LOAD: begin
        if (byte_valid) begin
          data_take_s = 1'b1;
          if (cnt_inc_s == len_r) begin
            ld_next = LD_FIN;
          end else begin
            ld_next = LD_LOAD;
          end
        end else begin
          ld_next = LD_LOAD;
        end
      end
      LD_FIN: begin
        ld_next = LD_FIN;
      end
      default: begin
        ld_next = LD_HDR;
      end
    endcase
  end

  // Header capture, byte counter, data shift register and write strobes.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      hdr_cnt_r  <= 2'd0;
      len_r      <= '0;
      byte_cnt_r <= '0;
      addr_r     <= '0;
      data_r     <= '0;
      we_32_r    <= 1'b0;
      we_128_r   <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      we_32_r  <= 1'b0;
      we_128_r <= 1'b0;
      done_r   <= (ld_r == LD_FIN);
      if (frame_err) begin
        err_r <= 1'b1;
      end
      if (hdr_take_s) begin
        hdr_cnt_r  <= hdr_cnt_r + 2'd1;
        byte_cnt_r <= '0;
        if (hdr_cnt_r == 2'd3) begin
          len_r <= effective_len(hdr_word_s);
        end else begin
          len_r <= hdr_word_s;
        end
      end
      if (data_take_s) begin
        data_r     <= {rx_byte, data_r[127:DATA_BITS]};
        byte_cnt_r <= cnt_inc_s;
        // Word complete: strobe next cycle with the word's start offset.
        if (cnt_inc_s[1:0] == 2'b00) begin
          we_32_r  <= 1'b1;
          addr_r   <= ADDR_W'(word_start_s);
          we_128_r <= (cnt_inc_s[3:0] == 4'b0000);
        end
      end
    end
  end

endmodule
